// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with a one-cycle output register.
// Define IFU_SKID_BUF_EN to add a one-entry skid buffer behind the output register.
module ifu (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [63:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t      state;
    logic [63:0] pc;
    logic        consume;
    logic        issue;
    logic        resp_live;

    assign consume   = inst_valid_o && !hold_i;
    assign resp_live = (state == S_WAIT) && imem_rvalid_i;

`ifdef IFU_SKID_BUF_EN
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [63:0] buf_addr;

    assign issue = !buf_valid;
`else
    assign issue = !inst_valid_o || !hold_i;
`endif

    assign imem_req_o  = (state == S_REQ) && issue;
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= 64'h0000_0000_8000_0000;
            inst_o       <= 32'h0;
            inst_addr_o  <= 64'h0;
            inst_valid_o <= 1'b0;
`ifdef IFU_SKID_BUF_EN
            buf_valid    <= 1'b0;
            buf_inst     <= 32'h0;
            buf_addr     <= 64'h0;
`endif
        end else if (jump_en_i) begin
            pc           <= {jump_addr_i[63:2], 2'b00};
            inst_valid_o <= 1'b0;
`ifdef IFU_SKID_BUF_EN
            buf_valid    <= 1'b0;
`endif
            // A response landing in the jump cycle is dropped here, so DRAIN has
            // nothing left to wait for and goes straight back to REQ.
            case (state)
                S_REQ:   state <= (imem_req_o && imem_gnt_i) ? S_DRAIN : S_REQ;
                S_WAIT:  state <= imem_rvalid_i ? S_REQ : S_DRAIN;
                default: state <= imem_rvalid_i ? S_REQ : S_DRAIN;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_o && imem_gnt_i)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        pc    <= pc + 64'd4;
                        state <= S_REQ;
                    end
                end
                default: begin
                    if (imem_rvalid_i)
                        state <= S_REQ;
                end
            endcase

`ifdef IFU_SKID_BUF_EN
            if (consume || !inst_valid_o) begin
                if (buf_valid) begin
                    inst_o       <= buf_inst;
                    inst_addr_o  <= buf_addr;
                    inst_valid_o <= 1'b1;
                    buf_valid    <= resp_live;
                    if (resp_live) begin
                        buf_inst <= imem_rdata_i;
                        buf_addr <= pc;
                    end
                end else if (resp_live) begin
                    inst_o       <= imem_rdata_i;
                    inst_addr_o  <= pc;
                    inst_valid_o <= 1'b1;
                end else begin
                    inst_valid_o <= 1'b0;
                end
            end else if (resp_live) begin
                buf_inst  <= imem_rdata_i;
                buf_addr  <= pc;
                buf_valid <= 1'b1;
            end
`else
            // Issue only happens when the slot will be free, so a response never collides.
            if (resp_live) begin
                inst_o       <= imem_rdata_i;
                inst_addr_o  <= pc;
                inst_valid_o <= 1'b1;
            end else if (consume) begin
                inst_valid_o <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios then randomized traffic against
// a transaction-level model of the fetch stream and a latency-randomized memory.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [63:0] jump_addr_i;
    logic        hold_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_o;
    logic        inst_valid_o;

    ifu dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_i       (hold_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } ent_t;

    int          tests = 0;
    int          fails = 0;
    bit          checking = 0;
    ent_t        exp_q[$];
    logic [63:0] m_pc = 64'h0000_0000_8000_0000;
    bit          m_out = 0;
    bit          m_live = 0;
    logic [63:0] m_addr = 64'h0;
    int          m_delay = 0;
    int          delay_max = 0;

    // Memory contents as a pure function of address; 0x80000000 holds 32'h00000413.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h8000_0413;
    endfunction

    function automatic bit issue_ok(input bit h);
`ifdef IFU_SKID_BUF_EN
        return exp_q.size() < 2;
`else
        return exp_q.size() == 0 || !h;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input bit r, input bit j, input logic [63:0] ja, input bit h, input bit g);
        bit          exp_req;
        bit          granted;
        bit          consume;
        bit          rv;
        logic [63:0] issue_pc;
        ent_t        e;
        @(negedge clk);
        rst         = r;
        jump_en_i   = j;
        jump_addr_i = ja;
        hold_i      = h;
        imem_gnt_i  = g;
        rv          = m_out && (m_delay == 0);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(m_addr) : $urandom;
        #1;
        exp_req = !m_out && issue_ok(h);
        if (checking) begin
            checkOutput("inst_valid", {63'h0, inst_valid_o}, {63'h0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                checkOutput("inst_addr", inst_addr_o, exp_q[0].addr);
                checkOutput("inst", {32'h0, inst_o}, {32'h0, exp_q[0].data});
            end
            checkOutput("imem_req", {63'h0, imem_req_o}, {63'h0, exp_req});
            if (exp_req)
                checkOutput("imem_addr", imem_addr_o, m_pc);
        end
        granted  = exp_req && g;
        consume  = (exp_q.size() != 0) && !h;
        issue_pc = m_pc;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_pc   = 64'h0000_0000_8000_0000;
            m_out  = 0;
            m_live = 0;
        end else begin
            if (m_out && !rv)
                m_delay--;
            if (rv)
                m_out = 0;
            if (j) begin
                exp_q.delete();
                m_pc   = {ja[63:2], 2'b00};
                m_live = 0;
            end else begin
                if (consume)
                    void'(exp_q.pop_front());
                if (rv && m_live) begin
                    e.addr = m_addr;
                    e.data = mem_word(m_addr);
                    exp_q.push_back(e);
                    m_pc = m_addr + 64'd4;
                end
            end
            if (granted) begin
                m_out   = 1;
                m_live  = !j;
                m_addr  = issue_pc;
                m_delay = $urandom_range(delay_max, 0);
            end
        end
    endtask

    initial begin
        logic [63:0] ja;
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 64'h0; hold_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;

        applyStimulus(1, 0, 64'h0, 0, 0);
        checking = 1;
        applyStimulus(1, 0, 64'h0, 0, 0);
        #1;
        checkOutput("rst_inst", {32'h0, inst_o}, 64'h0);
        checkOutput("rst_inst_addr", inst_addr_o, 64'h0);
        checkOutput("rst_pc", imem_addr_o, 64'h0000_0000_8000_0000);

        // Reset fetch: grant, response next cycle, then hold to observe the output.
        applyStimulus(0, 0, 64'h0, 0, 1);
        applyStimulus(0, 0, 64'h0, 0, 0);
        applyStimulus(0, 0, 64'h0, 1, 0);
        #1;
        checkOutput("first_inst", {32'h0, inst_o}, 64'h0000_0000_0000_0413);
        checkOutput("first_inst_addr", inst_addr_o, 64'h0000_0000_8000_0000);
        checkOutput("next_pc", imem_addr_o, 64'h0000_0000_8000_0004);

        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 64'h0, 1, 1);

        // Jump coinciding with the response, then a jump while waiting.
        applyStimulus(0, 0, 64'h0, 0, 1);
        applyStimulus(0, 0, 64'h0, 0, 1);
        applyStimulus(0, 1, 64'h0000_0000_8000_0200, 0, 0);
        applyStimulus(0, 0, 64'h0, 0, 1);
        m_delay = 2;
        applyStimulus(0, 1, 64'h0000_0000_8000_0102, 0, 0);
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 64'h0, 0, 1);

        // Reset while a fetch is outstanding.
        applyStimulus(0, 0, 64'h0, 0, 1);
        m_delay = 2;
        applyStimulus(1, 0, 64'h0, 0, 0);
        #1;
        checkOutput("midrst_pc", imem_addr_o, 64'h0000_0000_8000_0000);
        checkOutput("midrst_valid", {63'h0, inst_valid_o}, 64'h0);

        // Wrap from the top of the address space.
        applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        applyStimulus(0, 0, 64'h0, 0, 1);
        applyStimulus(0, 0, 64'h0, 0, 0);
        #1;
        checkOutput("wrap_pc", imem_addr_o, 64'h0);

        delay_max = 3;
        for (int i = 0; i < 3000; i++) begin
            ja = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            if ($urandom_range(15, 0) == 0)
                ja = 64'hFFFF_FFFF_FFFF_FFFE;
            applyStimulus($urandom_range(199, 0) == 0, $urandom_range(11, 0) == 0, ja,
                          $urandom_range(2, 0) == 0, $urandom_range(3, 0) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
